z80_mem_sched: RTL

//  Shares the single-port system memory (boot ROM overlay + RAM) between the Z80 CPU and the video fetcher.
//  - Runs a fixed-length memory access cycle and arbitrates round-robin between the two requesters.
//  - Stretches CPU cycles with wait.
//  - Holds the boot-overlay flag that steers CPU reads of low memory to the combinational boot ROM.
//  - Sits between the CPU bus glue and the RAM/ROM pair.

---
 rtl/z80_mem_sched.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/z80_mem_sched.sv
// Shared memory scheduler: one memory port time-sliced between the Z80 and the video
// fetcher with round-robin grants, fixed-length access cycles and a boot ROM overlay.
module z80_mem_sched #(
   parameter int ACC_CYC = 2,
   parameter int ROM_AW  = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_do,
   output logic [7:0]  cpu_di,
   output logic        cpu_ack,
   output logic        cpu_wait,
   input  logic        vid_req,
   input  logic [15:0] vid_a,
   output logic [7:0]  vid_d,
   output logic        vid_ack,
   input  logic        boot_clr,
   output logic        boot,
   output logic [15:0] mem_a,
   output logic [7:0]  mem_do,
   output logic        mem_we,
   input  logic [7:0]  mem_di,
   input  logic [7:0]  rom_d,
   output logic [1:0]  dbg_state
);

   localparam int CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CPU_ACC = 2'd1,
      VID_ACC = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   mem_a_q, mem_a_d;
   logic [7:0]    mem_do_q, mem_do_d;
   logic          mem_we_q, mem_we_d;
   logic [7:0]    cpu_di_q, cpu_di_d;
   logic [7:0]    vid_d_q, vid_d_d;
   logic          last_vid_q, last_vid_d;
   logic          rom_sel_q, rom_sel_d;
   logic          boot_q, boot_d;
   logic          in_window;

   // Handshake: each requester holds a level request (and its address/data) until
   // the one-clock ack; the ack cycle carries the read data, which then stays put.
   assign in_window = (cpu_a[15:ROM_AW] == '0);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mem_a_d    = mem_a_q;
      mem_do_d   = mem_do_q;
      mem_we_d   = mem_we_q;
      cpu_di_d   = cpu_di_q;
      vid_d_d    = vid_d_q;
      last_vid_d = last_vid_q;
      rom_sel_d  = rom_sel_q;
      boot_d     = boot_q & ~boot_clr;

      case (state_q)
         IDLE: begin
            if (cpu_req && (!vid_req || last_vid_q)) begin
               state_d   = CPU_ACC;
               mem_a_d   = cpu_a;
               mem_we_d  = cpu_we;
               mem_do_d  = cpu_do;
               // Overlay source is frozen at grant so a late boot_clr cannot split an access.
               rom_sel_d = boot_q & in_window;
               cnt_d     = CW'(ACC_CYC - 1);
            end else if (vid_req) begin
               state_d   = VID_ACC;
               mem_a_d   = vid_a;
               mem_we_d  = 1'b0;
               rom_sel_d = 1'b0;
               cnt_d     = CW'(ACC_CYC - 1);
            end
         end
         CPU_ACC, VID_ACC: begin
            if (cnt_q == '0) begin
               state_d    = DONE;
               mem_we_d   = 1'b0;
               last_vid_d = (state_q == VID_ACC);
               if (state_q == VID_ACC) begin
                  vid_d_d = mem_di;
               end else if (!mem_we_q) begin
                  // Writes leave the previous read data in place.
                  cpu_di_d = rom_sel_q ? rom_d : mem_di;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mem_a_q    <= '0;
         mem_do_q   <= '0;
         mem_we_q   <= 1'b0;
         cpu_di_q   <= '0;
         vid_d_q    <= '0;
         last_vid_q <= 1'b1;
         rom_sel_q  <= 1'b0;
         boot_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mem_a_q    <= mem_a_d;
         mem_do_q   <= mem_do_d;
         mem_we_q   <= mem_we_d;
         cpu_di_q   <= cpu_di_d;
         vid_d_q    <= vid_d_d;
         last_vid_q <= last_vid_d;
         rom_sel_q  <= rom_sel_d;
         boot_q     <= boot_d;
      end
   end

   assign cpu_ack   = (state_q == DONE) && !last_vid_q;
   assign vid_ack   = (state_q == DONE) && last_vid_q;
   assign cpu_wait  = cpu_req & ~cpu_ack;
   assign cpu_di    = cpu_di_q;
   assign vid_d     = vid_d_q;
   assign boot      = boot_q;
   assign mem_a     = mem_a_q;
   assign mem_do    = mem_do_q;
   assign mem_we    = mem_we_q;
   assign dbg_state = state_q;

endmodule
